// File: rtl/key_press_classifier_if.sv
// Command handshake between the key press classifier (producer) and the
// LED shifter (consumer): valid/ready with a 2-bit shift command.
interface key_press_classifier_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd;

  modport master (output cmd_valid, output cmd, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/key_press_classifier.sv
// key_press_classifier: synchronises and debounces the active-low KEY, times
// each press in whole seconds and, on release, offers HOLD/LEFT/RIGHT on the
// cmd interface. Define KEY_CLASS_OVERRUN_EN to add the sticky 'overrun'
// output flagging a pending command that was overwritten before acceptance.
module key_press_classifier #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LEFT_SEC     = 3,
  parameter int unsigned RIGHT_SEC    = 5
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET,
  input  logic                          KEY,
  key_press_classifier_if.master        cmd_if,
  output logic                          pressed,
  output logic [3:0]                    held_sec
`ifdef KEY_CLASS_OVERRUN_EN
  ,
  output logic                          overrun
`endif
);

  localparam int unsigned SUB_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  localparam logic [1:0] CMD_HOLD  = 2'b00;
  localparam logic [1:0] CMD_LEFT  = 2'b01;
  localparam logic [1:0] CMD_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_REPORT
  } state_t;

  logic             ks1_q, ks_q;
  logic             db_q;
  logic [DB_W-1:0]  dbc_q;
  state_t           state_q, state_d;
  logic [SUB_W-1:0] sub_q;
  logic [3:0]       held_q;
  logic             start_press, in_press, load_cmd;
  logic [1:0]       cmd_d;
  logic             cmd_valid_q;
  logic [1:0]       cmd_q;

  // Two-flop synchroniser followed by the stability-counter debouncer; db_q=1 means released
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      ks1_q <= 1'b0;
      ks_q  <= 1'b0;
      db_q  <= 1'b1;
      dbc_q <= '0;
    end else begin
      ks1_q <= KEY;
      ks_q  <= ks1_q;
      if (ks_q == db_q) begin
        dbc_q <= '0;
      end else if (dbc_q == DB_W'(DEBOUNCE_CYC - 1)) begin
        db_q  <= ks_q;
        dbc_q <= '0;
      end else begin
        dbc_q <= dbc_q + 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: REPORT is the one-cycle gap between release and cmd_valid
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!db_q) state_d = ST_PRESS;
      ST_PRESS:  if (db_q)  state_d = ST_REPORT;
      ST_REPORT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    start_press = (state_q == ST_IDLE) && !db_q;
    in_press    = (state_q == ST_PRESS);
    load_cmd    = (state_q == ST_REPORT);
  end

  // Press timer: whole seconds only, saturating at 15, frozen outside a press
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      sub_q  <= '0;
      held_q <= '0;
    end else if (start_press) begin
      sub_q  <= '0;
      held_q <= '0;
    end else if (in_press) begin
      if (sub_q == SUB_W'(CLK_HZ - 1)) begin
        sub_q <= '0;
        if (held_q != 4'hF) held_q <= held_q + 4'd1;
      end else begin
        sub_q <= sub_q + 1'b1;
      end
    end
  end

  // Classify the frozen press length
  always_comb begin
    if (32'(held_q) < LEFT_SEC)       cmd_d = CMD_HOLD;
    else if (32'(held_q) < RIGHT_SEC) cmd_d = CMD_LEFT;
    else                              cmd_d = CMD_RIGHT;
  end

  // Command holding register: a new classification wins over a same-cycle accept
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_HOLD;
    end else if (load_cmd) begin
      cmd_valid_q <= 1'b1;
      cmd_q       <= cmd_d;
    end else if (cmd_valid_q && cmd_if.cmd_ready) begin
      cmd_valid_q <= 1'b0;
    end
  end

`ifdef KEY_CLASS_OVERRUN_EN
  logic overrun_q;

  // Sticky flag: pending command replaced without having been accepted
  always_ff @(posedge CLOCK_50) begin
    if (RESET)                                            overrun_q <= 1'b0;
    else if (load_cmd && cmd_valid_q && !cmd_if.cmd_ready) overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;
`endif

  assign cmd_if.cmd_valid = cmd_valid_q;
  assign cmd_if.cmd       = cmd_q;
  assign pressed          = in_press;
  assign held_sec         = held_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// Randomised self-checking bench for key_press_classifier with a small clock
// second (10 cycles) and a 4-cycle debounce.
module tb_key_press_classifier;

  localparam int unsigned CLK_HZ = 10;
  localparam int unsigned DB     = 4;
  localparam int unsigned LEFT   = 3;
  localparam int unsigned RIGHT  = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       key;
  logic       pressed;
  logic [3:0] held_sec;
`ifdef KEY_CLASS_OVERRUN_EN
  logic       overrun;
`endif

  key_press_classifier_if cmd_if ();

  key_press_classifier #(
    .CLK_HZ      (CLK_HZ),
    .DEBOUNCE_CYC(DB),
    .LEFT_SEC    (LEFT),
    .RIGHT_SEC   (RIGHT)
  ) dut (
    .CLOCK_50(clk),
    .RESET   (rst),
    .KEY     (key),
    .cmd_if  (cmd_if),
    .pressed (pressed),
    .held_sec(held_sec)
`ifdef KEY_CLASS_OVERRUN_EN
    ,
    .overrun (overrun)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: whole seconds of a press lasting n cycles, saturating at 15
  function automatic int unsigned model_held(input int unsigned n);
    int unsigned s;
    s = n / CLK_HZ;
    return (s > 15) ? 15 : s;
  endfunction

  function automatic int unsigned model_cmd(input int unsigned secs);
    if (secs < LEFT)  return 0;
    if (secs < RIGHT) return 1;
    return 2;
  endfunction

  // Hold KEY low for n rising edges, checking the debounced level mid-press
  task automatic press(input int unsigned n);
    @(negedge clk);
    key = 1'b0;
    for (int unsigned i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == DB + 3) check_eq("pressed_mid", 32'(pressed), 32'd1);
    end
    key = 1'b1;
  endtask

  // Bounded wait for cmd_valid; reports the number of cycles taken
  task automatic wait_valid(output bit seen, output int unsigned cyc);
    seen = 1'b0;
    cyc  = 0;
    for (int unsigned i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (cmd_if.cmd_valid) begin
        seen = 1'b1;
        cyc  = i;
        break;
      end
    end
  endtask

  // Full press/release/classify/accept transaction against the model
  task automatic run_press(input int unsigned n, input bit rdy, input int unsigned hold_cyc);
    bit          seen;
    int unsigned cyc;
    int unsigned es;
    es = model_held(n);
    cmd_if.cmd_ready = rdy;
    press(n);
    wait_valid(seen, cyc);
    check_eq("valid_seen", 32'(seen), 32'd1);
    check_eq("latency", cyc, DB + 4);
    check_eq("cmd", 32'(cmd_if.cmd), model_cmd(es));
    check_eq("held_sec", 32'(held_sec), es);
    check_eq("pressed_rel", 32'(pressed), 32'd0);
    if (!rdy) begin
      for (int unsigned i = 0; i < hold_cyc; i++) begin
        @(negedge clk);
        check_eq("valid_hold", 32'(cmd_if.cmd_valid), 32'd1);
        check_eq("cmd_hold", 32'(cmd_if.cmd), model_cmd(es));
      end
      cmd_if.cmd_ready = 1'b1;
    end
    @(negedge clk);
    check_eq("valid_clear", 32'(cmd_if.cmd_valid), 32'd0);
    check_eq("held_frozen", 32'(held_sec), es);
    cmd_if.cmd_ready = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bit          seen;
    int unsigned cyc;
    bit          any_act;

    // Reset with KEY held low
    rst = 1'b1;
    key = 1'b0;
    cmd_if.cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_pressed", 32'(pressed), 32'd0);
    check_eq("rst_held", 32'(held_sec), 32'd0);
    check_eq("rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    check_eq("rst_cmd", 32'(cmd_if.cmd), 32'd0);
`ifdef KEY_CLASS_OVERRUN_EN
    check_eq("rst_overrun", 32'(overrun), 32'd0);
`endif
    rst = 1'b0;
    seen = 1'b0;
    for (int unsigned i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (pressed) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("rst_press_detect", 32'(seen), 32'd1);
    cmd_if.cmd_ready = 1'b1;
    key = 1'b1;
    wait_valid(seen, cyc);
    check_eq("rst_release_valid", 32'(seen), 32'd1);
    check_eq("rst_release_cmd", 32'(cmd_if.cmd), 32'd0);
    @(negedge clk);
    check_eq("rst_release_clear", 32'(cmd_if.cmd_valid), 32'd0);
    cmd_if.cmd_ready = 1'b0;
    repeat (10) @(negedge clk);

    // Directed: short HOLD, LEFT held pending, saturated RIGHT
    run_press(15, 1'b1, 0);
    run_press(35, 1'b0, 4);
    run_press(200, 1'b1, 0);

    // Bounce shorter than the debounce window
    key = 1'b0; repeat (2) @(negedge clk);
    key = 1'b1; repeat (2) @(negedge clk);
    key = 1'b0; repeat (2) @(negedge clk);
    key = 1'b1;
    any_act = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pressed || cmd_if.cmd_valid) any_act = 1'b1;
    end
    check_eq("glitch_quiet", 32'(any_act), 32'd0);

`ifdef KEY_CLASS_OVERRUN_EN
    check_eq("overrun_pre", 32'(overrun), 32'd0);
`endif
    // Overwrite of an unaccepted command: latest wins
    cmd_if.cmd_ready = 1'b0;
    press(15);
    repeat (12) @(negedge clk);
    check_eq("ovr_first_cmd", 32'(cmd_if.cmd), 32'd0);
    press(55);
    repeat (12) @(negedge clk);
    check_eq("ovr_valid", 32'(cmd_if.cmd_valid), 32'd1);
    check_eq("ovr_cmd", 32'(cmd_if.cmd), 32'd2);
    check_eq("ovr_held", 32'(held_sec), 32'd5);
`ifdef KEY_CLASS_OVERRUN_EN
    check_eq("overrun_set", 32'(overrun), 32'd1);
`endif
    cmd_if.cmd_ready = 1'b1;
    @(negedge clk);
    check_eq("ovr_clear", 32'(cmd_if.cmd_valid), 32'd0);
    cmd_if.cmd_ready = 1'b0;
    repeat (10) @(negedge clk);

    // Randomised presses against the model
    for (int k = 0; k < 12; k++) begin
      run_press($urandom_range(180, 8), 1'($urandom_range(1, 0)), $urandom_range(5, 1));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
